// File: rtl/nmk112_bank_mapper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nmk112_bank_mapper_pkg
//  Description : Shared constants, types and the page-select helper for the
//                NMK112 sample-ROM bank mapper.
//  Revision    : 1.0 - initial release
// ============================================================================
package nmk112_bank_mapper_pkg;

  localparam int          BANK_SHIFT        = 16;      // OKI address bit where the page field starts
  localparam int          BANK_W            = 4;       // width of one bank register
  localparam int          N_BANKS           = 4;       // bank register count
  localparam int          OKI_AW            = 18;      // OKI-side ROM address width
  localparam int          PCM_AW            = 21;      // physical PCM-ROM address width
  localparam int          TABLE_SLICE_SHIFT = 8;       // phrase table is paged in 256-byte slices
  localparam logic [17:0] TABLE_LIMIT       = 18'h400; // phrase-table area is 0x000-0x3FF

  typedef logic [1:0] bank_idx_t;

  // Which bank serves a given OKI address. Inside the phrase table the
  // 256-byte slice number picks the bank so that each voice's table entry
  // can live in a different physical bank.
  function automatic bank_idx_t page_sel(input logic [OKI_AW-1:0] addr,
                                         input logic              paged);
    bank_idx_t page;
    if (paged && (addr < TABLE_LIMIT))
      page = addr[TABLE_SLICE_SHIFT +: 2];
    else
      page = addr[BANK_SHIFT +: 2];
    return page;
  endfunction

endpackage : nmk112_bank_mapper_pkg
`default_nettype wire

// File: rtl/nmk112_bank_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : nmk112_bank_mapper
//  Description : NMK112-equivalent bank mapper for one OKI6295. Translates
//                the 18-bit OKI ROM address to a 21-bit PCM-ROM address
//                through four 4-bit bank registers.
//  Ports       : i_clk            system clock, rising edge
//                i_rst            synchronous active-high reset
//                i_offset[2:0]    bank-port offset ([1:0] first bank index)
//                i_data[7:0]      bank data (low nibble -> bank idx,
//                                 high nibble -> bank idx+1)
//                i_req_addr[17:0] OKI-side ROM address
//                o_req_data_addr  registered physical PCM-ROM address
//  Revision    : 1.0 - initial release
// ============================================================================
module nmk112_bank_mapper
  import nmk112_bank_mapper_pkg::*;
#(
  parameter logic [PCM_AW-1:0] ROM_OFFS    = 21'h000000,
  parameter bit                TABLE_PAGED = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_offset,
  input  logic [7:0]        i_data,
  input  logic [OKI_AW-1:0] i_req_addr,
  output logic [PCM_AW-1:0] o_req_data_addr
);

  logic [BANK_W-1:0] r_bank [0:N_BANKS-1];
  logic [PCM_AW-1:0] r_addr;

  bank_idx_t         w_idx_lo;
  bank_idx_t         w_idx_hi;
  bank_idx_t         w_page;
  logic [PCM_AW-1:0] w_local;
  logic [PCM_AW-1:0] w_phys;
  logic              w_unused_ok;

  // Chip select lives in the parent, so offset bit 2 carries no meaning here.
  assign w_unused_ok = &{1'b0, i_offset[2]};

  // The second nibble lands in the next bank; 2-bit arithmetic wraps 3 -> 0.
  assign w_idx_lo = i_offset[1:0];
  assign w_idx_hi = w_idx_lo + 2'd1;

  assign w_page  = page_sel(i_req_addr, TABLE_PAGED);
  assign w_local = {1'b0, r_bank[w_page], i_req_addr[BANK_SHIFT-1:0]};
  // 21-bit result: any carry out of the region offset add is dropped.
  assign w_phys  = ROM_OFFS + w_local;

  // No write strobe: the parent holds offset/data between port writes, so
  // reloading them every cycle is harmless.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_BANKS; i++)
        r_bank[i] <= '0;
      r_addr <= '0;
    end else begin
      r_bank[w_idx_lo] <= i_data[3:0];
      r_bank[w_idx_hi] <= i_data[7:4];
      r_addr           <= w_phys;
    end
  end

  assign o_req_data_addr = r_addr;

endmodule : nmk112_bank_mapper
`default_nettype wire

// File: tb/tb_nmk112_bank_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nmk112_bank_mapper
//  Description : Scoreboard bench for nmk112_bank_mapper. Three instances
//                share stimulus: A (offset 0, paged), B (offset 0x100000,
//                paged), C (offset 0, unpaged). Expected addresses are
//                hand-computed and queued with the cycle they must appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nmk112_bank_mapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  offset;
  logic [7:0]  data;
  logic [17:0] req;
  logic [20:0] out_a, out_b, out_c;

  nmk112_bank_mapper #(.ROM_OFFS(21'h000000), .TABLE_PAGED(1'b1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_offset(offset), .i_data(data),
    .i_req_addr(req), .o_req_data_addr(out_a));

  nmk112_bank_mapper #(.ROM_OFFS(21'h100000), .TABLE_PAGED(1'b1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_offset(offset), .i_data(data),
    .i_req_addr(req), .o_req_data_addr(out_b));

  nmk112_bank_mapper #(.ROM_OFFS(21'h000000), .TABLE_PAGED(1'b0)) u_c (
    .i_clk(clk), .i_rst(rst), .i_offset(offset), .i_data(data),
    .i_req_addr(req), .o_req_data_addr(out_c));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tcyc;
    int          dut;
    logic [20:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input int dut, input logic [20:0] val, input int d);
    exp_t e;
    e.tcyc = cyc + d;
    e.dut  = dut;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  // Expectations for all three instances, due d cycles from now.
  task automatic exp3(input string name, input logic [20:0] a, input logic [20:0] b,
                      input logic [20:0] c, input int d);
    push({name, "/A"}, 0, a, d);
    push({name, "/B"}, 1, b, d);
    push({name, "/C"}, 2, c, d);
  endtask

  // Apply one vector, queue its expectations, hold it until they are due.
  task automatic vec(input string name, input logic [2:0] o, input logic [7:0] dt,
                     input logic [17:0] r, input logic [20:0] a, input logic [20:0] b,
                     input logic [20:0] c);
    offset = o;
    data   = dt;
    req    = r;
    exp3(name, a, b, c, 2);
    step(2);
  endtask

  // Monitor: every cycle the output is presented, retire due entries.
  always @(negedge clk) begin
    logic [20:0] act;
    for (int i = 0; i < q.size(); ) begin
      if (q[i].tcyc <= cyc) begin
        act = (q[i].dut == 0) ? out_a : (q[i].dut == 1) ? out_b : out_c;
        n_tests++;
        if (q[i].tcyc < cyc) begin
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d not checked (now %0d)",
                   q[i].name, q[i].tcyc, cyc);
        end else if (act !== q[i].val) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h (cycle %0d)",
                   q[i].name, act, q[i].val, cyc);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    rst    = 1'b1;
    offset = 3'd0;
    data   = 8'h00;
    req    = 18'h12345;

    // Reset with address held: output must read zero.
    step(1);
    exp3("reset", 21'h0, 21'h0, 21'h0, 0);
    rst = 1'b0;
    exp3("post_reset", 21'h02345, 21'h102345, 21'h02345, 2);
    step(2);

    // bank0=1, bank1=2
    vec("b1_high", 3'd0, 8'h21, 18'h10010, 21'h20010, 21'h120010, 21'h20010);
    vec("b0_low",  3'd0, 8'h21, 18'h00500, 21'h10500, 21'h110500, 21'h10500);

    // bank2=3, bank3=4; paged instances pick slice banks in the table area
    vec("tbl_s2",   3'd2, 8'h43, 18'h00210, 21'h30210, 21'h130210, 21'h10210);
    vec("tbl_s3",   3'd2, 8'h43, 18'h00310, 21'h40310, 21'h140310, 21'h10310);
    vec("pg2",      3'd2, 8'h43, 18'h2ABCD, 21'h3ABCD, 21'h13ABCD, 21'h3ABCD);
    vec("tbl_last", 3'd2, 8'h43, 18'h003FF, 21'h403FF, 21'h1403FF, 21'h103FF);
    vec("tbl_end",  3'd2, 8'h43, 18'h00400, 21'h10400, 21'h110400, 21'h10400);

    // offset bit 2 ignored: 4 -> bank0/1=F, then 6 -> bank2=0, bank3=F
    vec("ofs4",     3'd4, 8'hFF, 18'h000FF, 21'h0F00FF, 21'h1F00FF, 21'h0F00FF);
    vec("ofs6_top", 3'd6, 8'hF0, 18'h3FFFF, 21'h0FFFFF, 21'h1FFFFF, 21'h0FFFFF);
    vec("ofs6_b2",  3'd6, 8'hF0, 18'h20000, 21'h000000, 21'h100000, 21'h000000);

    // Index wrap: offset 3 -> bank3=A, bank0=5 (bank1 stays F, bank2 0)
    vec("wrap_s1",  3'd3, 8'h5A, 18'h00123, 21'hF0123, 21'h1F0123, 21'h50123);
    vec("wrap_s3",  3'd3, 8'h5A, 18'h00323, 21'hA0323, 21'h1A0323, 21'h50323);
    vec("wrap_b3",  3'd3, 8'h5A, 18'h31111, 21'hA1111, 21'h1A1111, 21'hA1111);

    // Bank change visible only after 2 cycles: after 1 the old bank1 (F) shows.
    offset = 3'd0;
    data   = 8'h21;
    req    = 18'h10010;
    exp3("lat1", 21'hF0010, 21'h1F0010, 21'hF0010, 1);
    exp3("lat2", 21'h20010, 21'h120010, 21'h20010, 2);
    step(2);

    // One-cycle reset mid-stream with offset/data held.
    rst = 1'b1;
    exp3("mid_rst", 21'h0, 21'h0, 21'h0, 1);
    step(1);
    rst = 1'b0;
    exp3("rst_rel1", 21'h00010, 21'h100010, 21'h00010, 1);
    exp3("rst_rel2", 21'h20010, 21'h120010, 21'h20010, 2);
    step(2);
    vec("restored", 3'd0, 8'h21, 18'h00500, 21'h10500, 21'h110500, 21'h10500);

    // Drain with a bound.
    for (int k = 0; k < 10 && q.size() != 0; k++) step(1);
    while (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked (due cycle %0d)", q[0].name, q[0].tcyc);
      void'(q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_nmk112_bank_mapper
`default_nettype wire
